// File: rtl/simple_image_analyzer.sv
// Lane-position analyzer: accumulates left/right half pixel sums over a raster
// frame and emits the signed right-minus-left difference with a steering code.
module simple_image_analyzer #(
    parameter int IMG_WIDTH          = 32,
    parameter int IMG_HEIGHT         = 32,
    parameter int DECISION_THRESHOLD = 4096,
    parameter int IDLE_TIMEOUT       = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_signal,
    input  logic        pixel_valid,
    input  logic [7:0]  pixel_in,
    output logic        final_result_valid,
    output logic [47:0] final_lane_result,
    output logic        analyzer_busy
);

    localparam int FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
    localparam int COL_W        = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W        = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int TO_W         = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam int SUM_W        = 24;
    localparam int DIFF_W       = 46;
    localparam logic signed [DIFF_W-1:0] THRESH = DIFF_W'(DECISION_THRESHOLD);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RECEIVE = 2'b01,
        ST_COMPUTE = 2'b10,
        ST_OUTPUT  = 2'b11
    } state_t;

    state_t                    state_r;
    logic [COL_W-1:0]          col_r;
    logic [ROW_W-1:0]          row_r;
    logic [15:0]               pix_cnt_r;
    logic [TO_W-1:0]           idle_cnt_r;
    logic [SUM_W-1:0]          left_sum_r;
    logic [SUM_W-1:0]          right_sum_r;

    logic [SUM_W-1:0]          px_ext_s;
    logic                      is_left_s;
    logic                      last_col_s;
    logic                      last_pix_s;
    logic                      timeout_s;
    logic signed [DIFF_W-1:0]  diff_s;
    logic [1:0]                code_s;

    // Column/frame boundary flags, signed difference and steering decision
    always_comb begin
        px_ext_s   = {{(SUM_W-8){1'b0}}, pixel_in};
        is_left_s  = (col_r < COL_W'(IMG_WIDTH / 2));
        last_col_s = (col_r == COL_W'(IMG_WIDTH - 1));
        last_pix_s = (pix_cnt_r == 16'(FRAME_PIXELS - 1));
        timeout_s  = (idle_cnt_r == TO_W'(IDLE_TIMEOUT - 1));
        diff_s     = $signed({{(DIFF_W-SUM_W){1'b0}}, right_sum_r})
                   - $signed({{(DIFF_W-SUM_W){1'b0}}, left_sum_r});
        code_s     = 2'b00;
        if (diff_s > THRESH) begin
            code_s = 2'b10;
        end else if (diff_s < -THRESH) begin
            code_s = 2'b01;
        end else begin
            code_s = 2'b00;
        end
    end

    // Frame FSM, accumulators and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r            <= ST_IDLE;
            col_r              <= '0;
            row_r              <= '0;
            pix_cnt_r          <= 16'd0;
            idle_cnt_r         <= '0;
            left_sum_r         <= '0;
            right_sum_r        <= '0;
            final_result_valid <= 1'b0;
            final_lane_result  <= 48'd0;
            analyzer_busy      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    final_result_valid <= 1'b0;
                    if (start_signal) begin
                        state_r       <= ST_RECEIVE;
                        analyzer_busy <= 1'b1;
                        idle_cnt_r    <= '0;
                        row_r         <= '0;
                        right_sum_r   <= '0;
                        // A pixel arriving with the start pulse is pixel 0 (column 0, left half)
                        if (pixel_valid) begin
                            col_r      <= COL_W'(1);
                            pix_cnt_r  <= 16'd1;
                            left_sum_r <= px_ext_s;
                        end else begin
                            col_r      <= '0;
                            pix_cnt_r  <= 16'd0;
                            left_sum_r <= '0;
                        end
                    end else begin
                        analyzer_busy <= 1'b0;
                    end
                end
                ST_RECEIVE: begin
                    if (pixel_valid) begin
                        idle_cnt_r <= '0;
                        pix_cnt_r  <= pix_cnt_r + 16'd1;
                        if (is_left_s) begin
                            left_sum_r <= left_sum_r + px_ext_s;
                        end else begin
                            right_sum_r <= right_sum_r + px_ext_s;
                        end
                        if (last_col_s) begin
                            col_r <= '0;
                            row_r <= row_r + ROW_W'(1);
                        end else begin
                            col_r <= col_r + COL_W'(1);
                        end
                        if (last_pix_s) begin
                            state_r <= ST_COMPUTE;
                        end else begin
                            state_r <= ST_RECEIVE;
                        end
                    end else if (timeout_s) begin
                        state_r <= ST_COMPUTE;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + TO_W'(1);
                    end
                end
                ST_COMPUTE: begin
                    final_lane_result  <= {diff_s, code_s};
                    final_result_valid <= 1'b1;
                    state_r            <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    final_result_valid <= 1'b0;
                    analyzer_busy      <= 1'b0;
                    state_r            <= ST_IDLE;
                end
                default: begin
                    final_result_valid <= 1'b0;
                    analyzer_busy      <= 1'b0;
                    state_r            <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simple_image_analyzer.sv
// Bench for simple_image_analyzer: directed frame table, reset/idle sequences
// and randomized frames checked against a frame-level sum model.
module tb_simple_image_analyzer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_signal;
    logic        pixel_valid;
    logic [7:0]  pixel_in;
    logic        final_result_valid;
    logic [47:0] final_lane_result;
    logic        analyzer_busy;

    int n_pass  = 0;
    int n_total = 0;
    int pix_mem [1024];

    typedef struct {
        string       name;
        int          npix;
        int          left_val;
        int          right_val;
        int          bump_idx;
        int          bump_val;
        bit          restart;
        logic [47:0] exp_result;
        int          exp_lat;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    simple_image_analyzer dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start_signal       (start_signal),
        .pixel_valid        (pixel_valid),
        .pixel_in           (pixel_in),
        .final_result_valid (final_result_valid),
        .final_lane_result  (final_lane_result),
        .analyzer_busy      (analyzer_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_pattern(input int l, input int r, input int bi, input int bv);
        for (int i = 0; i < 1024; i++) begin
            if (i == bi) pix_mem[i] = bv;
            else if ((i % 32) < 16) pix_mem[i] = l;
            else pix_mem[i] = r;
        end
    endtask

    // Frame-level reference: right-half total minus left-half total, then threshold.
    function automatic logic [47:0] model_result(input int n);
        longint ls = 0;
        longint rs = 0;
        longint diff;
        longint code;
        for (int i = 0; i < n; i++) begin
            if ((i % 32) < 16) ls += pix_mem[i];
            else rs += pix_mem[i];
        end
        diff = rs - ls;
        if (diff > 4096) code = 2;
        else if (diff < -4096) code = 1;
        else code = 0;
        return 48'(diff * 4 + code);
    endfunction

    task automatic run_frame(input string name, input int n, input bit gaps, input bit restart,
                             input logic [47:0] exp, input int exp_lat);
        int          first_n = 0;
        int          npulse  = 0;
        logic [47:0] res_at  = 'x;
        logic        busy_at = 1'b0;
        logic        busy_after = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) begin
                int g = $urandom_range(0, 2);
                repeat (g) begin
                    start_signal = 1'b0;
                    pixel_valid  = 1'b0;
                    step();
                end
            end
            start_signal = (i == 0) || (restart && i == 500);
            pixel_valid  = 1'b1;
            pixel_in     = 8'(pix_mem[i]);
            step();
            if (i == 0) check({name, "/busy_rise"}, 64'(analyzer_busy), 64'd1);
        end
        start_signal = 1'b0;
        pixel_valid  = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (final_result_valid) begin
                npulse++;
                if (first_n == 0) begin
                    first_n = k;
                    res_at  = final_lane_result;
                    busy_at = analyzer_busy;
                end
            end
            if (first_n != 0 && k == first_n + 1) busy_after = analyzer_busy;
        end
        check({name, "/pulses"},     64'(npulse),  64'd1);
        check({name, "/latency"},    64'(first_n), 64'(exp_lat));
        check({name, "/result"},     64'(res_at),  64'(exp));
        check({name, "/busy_out"},   64'(busy_at), 64'd1);
        check({name, "/busy_after"}, 64'(busy_after), 64'd0);
        check({name, "/hold"},       64'(final_lane_result), 64'(exp));
    endtask

    initial begin
        int npulse;
        int n;
        vecs[0] = '{"all_zero",   1024, 0,   0,   -1, 0,   1'b0, 48'h0,            2};
        vecs[1] = '{"right255",   1024, 0,   255, -1, 0,   1'b0, 48'h7F802,        2};
        vecs[2] = '{"left255",    1024, 255, 0,   -1, 0,   1'b0, 48'hFFFFFFF80801, 2};
        vecs[3] = '{"uniform100", 1024, 100, 100, -1, 0,   1'b1, 48'h0,            2};
        vecs[4] = '{"partial1021",1021, 0,   255, -1, 0,   1'b0, 48'h7EC0E,        66};
        vecs[5] = '{"thr_pos_eq", 64,   0,   128, -1, 0,   1'b0, 48'h4000,         66};
        vecs[6] = '{"thr_pos_gt", 64,   0,   128, 63, 129, 1'b0, 48'h4006,         66};
        vecs[7] = '{"thr_neg_eq", 64,   128, 0,   -1, 0,   1'b0, 48'hFFFFFFFFC000, 66};
        vecs[8] = '{"thr_neg_gt", 64,   128, 0,   47, 129, 1'b0, 48'hFFFFFFFFBFFD, 66};

        rst_n = 1'b0; start_signal = 1'b0; pixel_valid = 1'b0; pixel_in = 8'd0;
        repeat (3) step();
        check("reset/busy",   64'(analyzer_busy),      64'd0);
        check("reset/valid",  64'(final_result_valid), 64'd0);
        check("reset/result", 64'(final_lane_result),  64'd0);
        rst_n = 1'b1;

        // Pixels without start must not open a frame
        npulse = 0;
        pixel_valid = 1'b1; pixel_in = 8'd200;
        repeat (5) step();
        check("idle_pix/busy", 64'(analyzer_busy), 64'd0);
        pixel_valid = 1'b0;
        repeat (80) begin
            step();
            if (final_result_valid) npulse++;
        end
        check("idle_pix/pulses", 64'(npulse), 64'd0);

        foreach (vecs[v]) begin
            fill_pattern(vecs[v].left_val, vecs[v].right_val, vecs[v].bump_idx, vecs[v].bump_val);
            run_frame(vecs[v].name, vecs[v].npix, 1'b0, vecs[v].restart,
                      vecs[v].exp_result, vecs[v].exp_lat);
        end

        // Reset in the middle of a frame discards it
        fill_pattern(100, 100, -1, 0);
        for (int i = 0; i < 500; i++) begin
            start_signal = (i == 0);
            pixel_valid  = 1'b1;
            pixel_in     = 8'(pix_mem[i]);
            step();
        end
        start_signal = 1'b0; pixel_valid = 1'b0;
        rst_n = 1'b0;
        step();
        check("midreset/busy",   64'(analyzer_busy),     64'd0);
        check("midreset/result", 64'(final_lane_result), 64'd0);
        rst_n = 1'b1;
        npulse = 0;
        repeat (100) begin
            step();
            if (final_result_valid) npulse++;
        end
        check("midreset/pulses", 64'(npulse), 64'd0);
        fill_pattern(0, 255, -1, 0);
        run_frame("after_reset", 1024, 1'b0, 1'b0, 48'h7F802, 2);

        // Randomized frames with random gaps against the sum model
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 1024; i++) pix_mem[i] = int'($urandom_range(0, 255));
            n = ($urandom_range(0, 1) == 1) ? 1024 : int'($urandom_range(100, 1023));
            run_frame($sformatf("rand%0d", r), n, 1'b1, 1'b0, model_result(n), (n == 1024) ? 2 : 66);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
